stream_mux: RTL and testbench
=============================

// Module: stream_mux
// PURPOSE
//  - N-input, WIDTH-bit registered stream multiplexer with valid/ready handshake; successor to the
//    combinational 2:1 datapath mux. Selects one producer per cycle and drives a one-stage output register.
//  - Two modes: external select (decode/execute operand paths) and round-robin arbitration (shared
//    consumers, e.g. memory-port or writeback sharing). Reports the winning channel index with the data.
// PARAMETERS
//  WIDTH   32  data width per channel
//  N_IN    4   number of input channels, >=2
//  MODE    0   0 = MODE_SEL (i_sel chooses channel), 1 = MODE_RR (round-robin among valid inputs)
//  SEL_W   $clog2(N_IN)  localparam, width of select/channel index
// PORTS
//  i_clk     in   1            clock, rising edge
//  i_rst     in   1            reset, asynchronous, active-high
//  i_valid   in   N_IN         per-channel valid
//  i_data    in   N_IN*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//  o_ready   out  N_IN         per-channel ready, one-hot or zero
//  i_sel     in   SEL_W        channel select, used in MODE_SEL only
//  o_valid   out  1            output register holds data
//  o_data    out  WIDTH        registered data
//  o_chan    out  SEL_W        channel index of o_data
//  i_ready   in   1            downstream accepts o_data
//  o_count   out  32           transfers accepted since reset, wraps at 2^32
// BEHAVIOUR
//  - Reset (async, active-high): o_valid=0, o_data=0, o_chan=0, o_count=0, RR pointer=0. o_ready=0 while
//    i_rst=1. Reset mid-transfer drops any held word; nothing is replayed.
//  - can_load = !o_valid || i_ready. Grant g is computed combinationally each cycle.
//    o_ready[g]=can_load && grant_valid; every other bit of o_ready is 0. o_ready never depends on i_valid[g].
//  - Input transfer on channel g: i_valid[g] && o_ready[g]. At the next edge: o_data<=i_data[g],
//    o_chan<=g, o_valid<=1, o_count<=o_count+1.
//  - Output transfer: o_valid && i_ready. If there is no input transfer in the same cycle, o_valid<=0.
//    Simultaneous input and output transfers keep o_valid=1 with the new word. Full throughput is 1 word/cycle.
//  - While o_valid && !i_ready, o_data and o_chan stay stable (no overwrite).
//  - Latency: 1 cycle from input transfer to o_valid.
//  - MODE_SEL: g=i_sel and grant_valid=(i_sel<N_IN). An out-of-range i_sel grants nothing and raises no
//    o_ready. Valid lines on unselected channels are ignored.
//  - MODE_RR: scan channels ptr, ptr+1, ... mod N_IN. The first channel with i_valid=1 wins.
//    grant_valid=|i_valid.
//    - After an input transfer from channel g, ptr<=(g+1) mod N_IN. This wraps from N_IN-1 to 0.
//    - ptr is unchanged when no input transfer happens, including a stalled grant. This makes the
//      arbiter work-conserving and starvation-free.
//  - o_count wraps 0xFFFF_FFFF -> 0 silently.
//  - Protocol rule for producers: once i_valid[k] is asserted, it and i_data[k] stay stable until transfer.
//    The block does not check this rule.
// STRUCTURE
//  - Shared package mux_pkg: MODE_SEL=0 and MODE_RR=1 constants, plus the function clog2_min1 (returns
//    1 when N_IN<=2).
//  - Sub-module rr_arbiter #(N_IN): inputs i_clk, i_rst, i_req[N_IN], i_advance, i_adv_idx; outputs
//    o_gnt_idx and o_gnt_valid. It holds the rotating pointer and is instantiated only when MODE=MODE_RR.
//  - The top level contains the grant mux, the output register and the counter.
// TESTING
//  1. MODE_SEL, N_IN=4, i_sel=2, i_valid=4'b0100, i_data[2]=0xDEADBEEF, i_ready=1:
//     o_ready=4'b0100; next cycle o_valid=1, o_data=0xDEADBEEF, o_chan=2, o_count=1.
//  2. Backpressure: load 0x11, hold i_ready=0 for 3 cycles while channel 1 presents 0x22:
//     o_ready=0, o_data stays 0x11. Raise i_ready: 0x11 drains, 0x22 loads the same cycle, o_valid stays 1.
//  3. MODE_RR, i_valid=4'b1111 constant, i_ready=1: o_chan sequence 0,1,2,3,0,1 on consecutive cycles;
//     o_count increments every cycle.
//  4. MODE_RR, ptr=3, i_valid=4'b0011: grant 0, then 1, then 0.
//     Out-of-range i_sel=5 with N_IN=5 in MODE_SEL: o_ready=0, o_valid stays 0.
//  5. Assert i_rst asynchronously mid-stream with o_valid=1: o_valid, o_data, o_chan and o_count go to 0
//     immediately. The first RR grant after release is channel 0.
//  6. Preload o_count=0xFFFFFFFF via force, then one transfer: o_count=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package mux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: rotating-priority grant with pointer advanced only on accepted transfers.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = clog2_min1(N_IN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IN-1:0]  i_req,
  input  logic             i_advance,
  input  logic [SEL_W-1:0] i_adv_idx,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid
);

  logic [SEL_W-1:0] ptr;
  int unsigned      idx;

  // Scan ptr, ptr+1, ... (mod N_IN); first requester wins.
  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!o_gnt_valid && i_req[SEL_W'(idx)]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = SEL_W'(idx);
      end
    end
  end

  // Pointer moves past the winner only when its word is actually taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (i_advance) begin
      ptr <= (32'(i_adv_idx) == N_IN - 1) ? '0 : i_adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input registered stream multiplexer with external-select or round-robin grant.
module stream_mux
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned N_IN  = 4,
  parameter  int unsigned MODE  = MODE_SEL,
  localparam int unsigned SEL_W = clog2_min1(N_IN)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_IN-1:0]       i_valid,
  input  logic [N_IN*WIDTH-1:0] i_data,
  output logic [N_IN-1:0]       o_ready,
  input  logic [SEL_W-1:0]      i_sel,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic [SEL_W-1:0]      o_chan,
  input  logic                  i_ready,
  output logic [31:0]           o_count
);

  logic [SEL_W-1:0] grant_idx;
  logic             grant_valid;
  logic             can_load;
  logic             load_ok;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             in_xfer;

  assign can_load = !o_valid || i_ready;
  assign load_ok  = grant_valid && can_load && !i_rst;
  assign in_xfer  = load_ok && sel_valid;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^i_sel;

      rr_arbiter #(.N_IN(N_IN)) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_valid),
        .i_advance   (in_xfer),
        .i_adv_idx   (grant_idx),
        .o_gnt_idx   (grant_idx),
        .o_gnt_valid (grant_valid)
      );
    end else begin : g_sel
      assign grant_idx   = i_sel;
      assign grant_valid = 32'(i_sel) < N_IN;
    end
  endgenerate

  // Grant mux: route the granted channel and raise its ready; ready ignores that channel's valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    o_ready   = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        sel_valid  = i_valid[k];
        sel_data   = i_data[k*WIDTH +: WIDTH];
        o_ready[k] = load_ok;
      end
    end
  end

  // One-stage output register and transfer counter; a held word is never overwritten.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      o_count <= '0;
    end else if (in_xfer) begin
      o_valid <= 1'b1;
      o_data  <= sel_data;
      o_chan  <= grant_idx;
      o_count <= o_count + 32'd1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: select mode (4 and 5 channels) and round-robin mode.
module tb_stream_mux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: MODE_SEL, 4 channels
  logic [3:0]   a_valid = '0;
  logic [127:0] a_data  = '0;
  logic [3:0]   a_ready_o;
  logic [1:0]   a_sel   = '0;
  logic         a_ovalid;
  logic [31:0]  a_odata;
  logic [1:0]   a_chan;
  logic         a_iready = 1'b0;
  logic [31:0]  a_count;

  // DUT B: MODE_RR, 4 channels
  logic [3:0]   b_valid = '0;
  logic [127:0] b_data  = '0;
  logic [3:0]   b_ready_o;
  logic [1:0]   b_sel   = '0;
  logic         b_ovalid;
  logic [31:0]  b_odata;
  logic [1:0]   b_chan;
  logic         b_iready = 1'b0;
  logic [31:0]  b_count;

  // DUT C: MODE_SEL, 5 channels (3-bit select with out-of-range codes)
  logic [4:0]   c_valid = '0;
  logic [159:0] c_data  = '0;
  logic [4:0]   c_ready_o;
  logic [2:0]   c_sel   = '0;
  logic         c_ovalid;
  logic [31:0]  c_odata;
  logic [2:0]   c_chan;
  logic         c_iready = 1'b0;
  logic [31:0]  c_count;

  stream_mux #(.WIDTH(32), .N_IN(4), .MODE(0)) u_sel4 (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_data(a_data), .o_ready(a_ready_o),
    .i_sel(a_sel), .o_valid(a_ovalid), .o_data(a_odata), .o_chan(a_chan),
    .i_ready(a_iready), .o_count(a_count)
  );

  stream_mux #(.WIDTH(32), .N_IN(4), .MODE(1)) u_rr4 (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready_o),
    .i_sel(b_sel), .o_valid(b_ovalid), .o_data(b_odata), .o_chan(b_chan),
    .i_ready(b_iready), .o_count(b_count)
  );

  stream_mux #(.WIDTH(32), .N_IN(5), .MODE(0)) u_sel5 (
    .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .i_data(c_data), .o_ready(c_ready_o),
    .i_sel(c_sel), .o_valid(c_ovalid), .o_data(c_odata), .o_chan(c_chan),
    .i_ready(c_iready), .o_count(c_count)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 4'b1111; a_iready = 1'b1;
    b_valid = 4'b1111; b_iready = 1'b1;
    #1;
    checks++; if (a_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready_sel: got %b expected %b", a_ready_o, 4'b0000); end
    checks++; if (b_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready_rr: got %b expected %b", b_ready_o, 4'b0000); end
    tick();
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_ovalid); end
    checks++; if (a_odata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", a_odata); end
    checks++; if (a_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", a_count); end
    @(negedge clk);
    a_valid = '0; b_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_sel();
    a_sel = 2'd2; a_valid = 4'b0100; a_data = '0; a_data[64 +: 32] = 32'hDEADBEEF; a_iready = 1'b1;
    #1;
    checks++; if (a_ready_o !== 4'b0100) begin errors++; $display("FAIL sel_ready: got %b expected %b", a_ready_o, 4'b0100); end
    tick();
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL sel_valid: got %b expected 1", a_ovalid); end
    checks++; if (a_odata !== 32'hDEADBEEF) begin errors++; $display("FAIL sel_data: got %h expected deadbeef", a_odata); end
    checks++; if (a_chan !== 2'd2) begin errors++; $display("FAIL sel_chan: got %0d expected 2", a_chan); end
    checks++; if (a_count !== 32'd1) begin errors++; $display("FAIL sel_count: got %0d expected 1", a_count); end
    @(negedge clk);
    // only an unselected channel is valid: ready stays on channel 2, nothing loads
    a_valid = 4'b0010;
    #1;
    checks++; if (a_ready_o !== 4'b0100) begin errors++; $display("FAIL sel_ready_unsel: got %b expected %b", a_ready_o, 4'b0100); end
    tick();
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL sel_drain: got %b expected 0", a_ovalid); end
    checks++; if (a_count !== 32'd1) begin errors++; $display("FAIL sel_ignore_count: got %0d expected 1", a_count); end
    @(negedge clk);
    a_valid = '0;
  endtask

  task automatic test_backpressure();
    a_sel = 2'd0; a_valid = 4'b0001; a_data = '0; a_data[0 +: 32] = 32'h11; a_iready = 1'b1;
    tick();
    checks++; if (a_odata !== 32'h11) begin errors++; $display("FAIL bp_load: got %h expected 11", a_odata); end
    @(negedge clk);
    a_sel = 2'd1; a_valid = 4'b0010; a_data[32 +: 32] = 32'h22; a_iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0000", i, a_ready_o); end
      tick();
      checks++; if (a_odata !== 32'h11 || a_chan !== 2'd0 || a_ovalid !== 1'b1)
        begin errors++; $display("FAIL bp_hold_%0d: got v=%b d=%h c=%0d expected v=1 d=11 c=0", i, a_ovalid, a_odata, a_chan); end
      @(negedge clk);
    end
    a_iready = 1'b1;
    #1;
    checks++; if (a_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", a_ready_o); end
    tick();
    checks++; if (a_ovalid !== 1'b1 || a_odata !== 32'h22 || a_chan !== 2'd1)
      begin errors++; $display("FAIL bp_swap: got v=%b d=%h c=%0d expected v=1 d=22 c=1", a_ovalid, a_odata, a_chan); end
    checks++; if (a_count !== 32'd3) begin errors++; $display("FAIL bp_count: got %0d expected 3", a_count); end
    @(negedge clk);
    a_valid = '0;
    tick();
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", a_ovalid); end
    @(negedge clk);
  endtask

  task automatic test_rr();
    logic [1:0] exp_chan [6];
    logic [1:0] exp_b    [4];
    logic [3:0] exp_rdy;
    exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    b_valid = 4'b1111; b_iready = 1'b1;
    b_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 4'b0001 << exp_chan[i];
      #1;
      checks++; if (b_ready_o !== exp_rdy) begin errors++; $display("FAIL rr_ready_%0d: got %b expected %b", i, b_ready_o, exp_rdy); end
      tick();
      checks++; if (b_chan !== exp_chan[i] || b_count !== 32'(i + 1))
        begin errors++; $display("FAIL rr_seq_%0d: got c=%0d n=%0d expected c=%0d n=%0d", i, b_chan, b_count, exp_chan[i], i + 1); end
      @(negedge clk);
    end
    // pointer is now 2; one grant to channel 2 moves it to 3
    b_valid = 4'b0100;
    tick();
    checks++; if (b_chan !== 2'd2) begin errors++; $display("FAIL rr_to_ptr3: got %0d expected 2", b_chan); end
    @(negedge clk);
    b_valid = 4'b0011;
    exp_b = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 3; i++) begin
      exp_rdy = 4'b0001 << exp_b[i];
      #1;
      checks++; if (b_ready_o !== exp_rdy) begin errors++; $display("FAIL rr_wrap_ready_%0d: got %b expected %b", i, b_ready_o, exp_rdy); end
      tick();
      checks++; if (b_chan !== exp_b[i] || b_count !== 32'(8 + i))
        begin errors++; $display("FAIL rr_wrap_%0d: got c=%0d n=%0d expected c=%0d n=%0d", i, b_chan, b_count, exp_b[i], 8 + i); end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range();
    c_sel = 3'd5; c_valid = 5'b11111; c_iready = 1'b1;
    c_data = {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};
    #1;
    checks++; if (c_ready_o !== 5'b00000) begin errors++; $display("FAIL oor_ready: got %b expected 00000", c_ready_o); end
    tick();
    checks++; if (c_ovalid !== 1'b0) begin errors++; $display("FAIL oor_valid: got %b expected 0", c_ovalid); end
    @(negedge clk);
    c_sel = 3'd4;
    #1;
    checks++; if (c_ready_o !== 5'b10000) begin errors++; $display("FAIL top_ready: got %b expected 10000", c_ready_o); end
    tick();
    checks++; if (c_ovalid !== 1'b1 || c_odata !== 32'hC4 || c_chan !== 3'd4)
      begin errors++; $display("FAIL top_chan: got v=%b d=%h c=%0d expected v=1 d=c4 c=4", c_ovalid, c_odata, c_chan); end
    @(negedge clk);
    c_valid = '0;
  endtask

  task automatic test_async_reset();
    // u_rr4 still streams 0011 from the previous test; last grant was 0 so ptr=1
    b_valid = 4'b1111;
    tick();
    checks++; if (b_ovalid !== 1'b1 || b_chan !== 2'd1) begin errors++; $display("FAIL ar_pre: got v=%b c=%0d expected v=1 c=1", b_ovalid, b_chan); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (b_ovalid !== 1'b0 || b_odata !== 32'h0 || b_chan !== 2'd0 || b_count !== 32'h0)
      begin errors++; $display("FAIL ar_clear: got v=%b d=%h c=%0d n=%0d expected all 0", b_ovalid, b_odata, b_chan, b_count); end
    checks++; if (b_ready_o !== 4'b0000) begin errors++; $display("FAIL ar_ready: got %b expected 0000", b_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    b_valid = 4'b1110;
    b_valid = 4'b1111;
    #1;
    checks++; if (b_ready_o !== 4'b0001) begin errors++; $display("FAIL ar_first_ready: got %b expected 0001", b_ready_o); end
    tick();
    checks++; if (b_chan !== 2'd0 || b_count !== 32'd1) begin errors++; $display("FAIL ar_first_grant: got c=%0d n=%0d expected c=0 n=1", b_chan, b_count); end
    @(negedge clk);
    b_valid = '0;
  endtask

  task automatic test_wrap();
    a_sel = 2'd3; a_valid = '0; a_iready = 1'b1;
    tick();
    @(negedge clk);
    force u_sel4.o_count = 32'hFFFFFFFF;
    #1;
    release u_sel4.o_count;
    #1;
    checks++; if (a_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", a_count); end
    a_valid = 4'b1000; a_data[96 +: 32] = 32'h33;
    tick();
    checks++; if (a_count !== 32'h0 || a_odata !== 32'h33) begin errors++; $display("FAIL wrap: got n=%h d=%h expected n=0 d=33", a_count, a_odata); end
    @(negedge clk);
    a_valid = '0;
  endtask

  initial begin
    test_reset();
    test_sel();
    test_backpressure();
    test_rr();
    test_out_of_range();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
